// File: rtl/skolem_sweep_ctrl_if.sv
// Handshake bundle between the host/checker side and the sweep sequencer.
interface skolem_sweep_ctrl_if #(
    parameter int N_IN = 8
);
    logic            start;
    logic            abort;
    logic            stop_on_fail;
    logic [N_IN-1:0] vec_out;
    logic            vec_valid;
    logic            chk_ok;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_vld;

    modport master (
        output start, abort, stop_on_fail, chk_ok,
        input  vec_out, vec_valid, busy, done, pass, fail_cnt, first_fail, first_fail_vld
    );

    modport slave (
        input  start, abort, stop_on_fail, chk_ok,
        output vec_out, vec_valid, busy, done, pass, fail_cnt, first_fail, first_fail_vld
    );
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep sequencer: issues every N_IN-bit assignment once per cycle,
// scores the checker verdict LAT cycles later and reports count/first/pass.
module skolem_sweep_ctrl #(
    parameter int N_IN = 8,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    skolem_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [N_IN:0]   cnt_p0;            // next vector to issue; MSB set = space exhausted
    logic [N_IN-1:0] vec_p0;
    logic            vld_p0;
    logic            sol_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN:0]   fail_cnt_q;
    logic [N_IN-1:0] first_fail_q;
    logic            first_fail_vld_q;

    logic            tap_vld;
    logic [N_IN-1:0] tap_vec;
    logic            pend;
    logic            flush;
    logic            fail_hit;
    logic [N_IN:0]   fail_cnt_nxt;

    assign flush        = bus.abort && (state == S_DRIVE || state == S_DRAIN);
    assign fail_hit     = tap_vld && !bus.chk_ok;
    assign fail_cnt_nxt = fail_cnt_q + {{N_IN{1'b0}}, fail_hit};

    generate
        if (LAT == 0) begin : g_nodly
            // verdict belongs to the vector on vec_out this very cycle
            assign tap_vld = vld_p0;
            assign tap_vec = vec_p0;
            assign pend    = 1'b0;
        end else begin : g_dly
            logic [N_IN-1:0] dly_vec_p [LAT];
            logic            dly_vld_p [LAT];

            // shift {valid, vector} toward the scoring tap; only valids are cleared
            always_ff @(posedge clk) begin
                dly_vec_p[0] <= vec_p0;
                dly_vld_p[0] <= vld_p0;
                for (int i = 1; i < LAT; i++) begin
                    dly_vec_p[i] <= dly_vec_p[i-1];
                    dly_vld_p[i] <= dly_vld_p[i-1];
                end
                if (rst || flush) begin
                    for (int i = 0; i < LAT; i++) dly_vld_p[i] <= 1'b0;
                end
            end

            // entries that will still be in flight after the current edge
            always_comb begin
                pend = 1'b0;
                for (int i = 0; i < LAT - 1; i++) pend = pend | dly_vld_p[i];
            end

            assign tap_vld = dly_vld_p[LAT-1];
            assign tap_vec = dly_vec_p[LAT-1];
        end
    endgenerate

    // sweep FSM, vector issue, scoring and result registers
    always_ff @(posedge clk) begin
        done_q <= 1'b0;
        if (rst) begin
            state            <= S_IDLE;
            cnt_p0           <= '0;
            vec_p0           <= '0;
            vld_p0           <= 1'b0;
            sol_q            <= 1'b0;
            busy_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_cnt_q       <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
        end else begin
            if (fail_hit && !flush) begin
                fail_cnt_q <= fail_cnt_nxt;
                if (!first_fail_vld_q) begin
                    first_fail_q     <= tap_vec;
                    first_fail_vld_q <= 1'b1;
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state            <= S_DRIVE;
                        busy_q           <= 1'b1;
                        vec_p0           <= '0;
                        vld_p0           <= 1'b1;
                        cnt_p0           <= {{N_IN{1'b0}}, 1'b1};
                        sol_q            <= bus.stop_on_fail;
                        pass_q           <= 1'b0;
                        fail_cnt_q       <= '0;
                        first_fail_q     <= '0;
                        first_fail_vld_q <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        vld_p0 <= 1'b0;
                        pass_q <= 1'b0;
                    end else if (cnt_p0[N_IN] || (sol_q && fail_hit)) begin
                        vld_p0 <= 1'b0;
                        cnt_p0 <= '0;
                        if (LAT == 0) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (fail_cnt_nxt == '0);
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        vec_p0 <= cnt_p0[N_IN-1:0];
                        cnt_p0 <= cnt_p0 + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        pass_q <= 1'b0;
                    end else if (!pend) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (fail_cnt_nxt == '0);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.vec_out        = vec_p0;
    assign bus.vec_valid      = vld_p0;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.fail_cnt       = fail_cnt_q;
    assign bus.first_fail     = first_fail_q;
    assign bus.first_fail_vld = first_fail_vld_q;
endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Bench for skolem_sweep_ctrl: two instances (N_IN=8/LAT=2 and N_IN=3/LAT=0)
// driven by a checker model that fails a chosen set of vectors.
module tb_skolem_sweep_ctrl;
    localparam int NA = 8, LA = 2, NB = 3, LB = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    skolem_sweep_ctrl_if #(.N_IN(NA)) ifa ();
    skolem_sweep_ctrl_if #(.N_IN(NB)) ifb ();

    skolem_sweep_ctrl #(.N_IN(NA), .LAT(LA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    skolem_sweep_ctrl #(.N_IN(NB), .LAT(LB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    bit in_start [2];
    bit in_abort [2];
    bit in_sol   [2];
    bit in_chk   [2];

    assign ifa.start = in_start[0];  assign ifb.start = in_start[1];
    assign ifa.abort = in_abort[0];  assign ifb.abort = in_abort[1];
    assign ifa.stop_on_fail = in_sol[0];  assign ifb.stop_on_fail = in_sol[1];
    assign ifa.chk_ok = in_chk[0];   assign ifb.chk_ok = in_chk[1];

    int lat [2];
    int nvec [2];
    bit bad [2][256];
    int h_vld [2][16];
    int h_vec [2][16];
    int cyc = 0;
    int s_vv[2], s_vec[2], s_busy[2], s_done[2], s_pass[2], s_cnt[2], s_ff[2], s_ffv[2];
    int n_chk = 0, n_pass = 0;

    typedef struct {
        int d; bit sol; bit noise; bit odd;
        int nb; int b0; int b1;
        int x_cnt; int x_ff; int x_ffv; int x_pass; int x_doff;
    } rec_t;
    rec_t tbl [9];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // advance one clock, sample outputs, then drive the checker verdicts
    task automatic step();
        int idx;
        @(posedge clk);
        #1;
        cyc++;
        s_vv[0] = ifa.vec_valid; s_vec[0] = ifa.vec_out; s_busy[0] = ifa.busy; s_done[0] = ifa.done;
        s_pass[0] = ifa.pass; s_cnt[0] = ifa.fail_cnt; s_ff[0] = ifa.first_fail; s_ffv[0] = ifa.first_fail_vld;
        s_vv[1] = ifb.vec_valid; s_vec[1] = ifb.vec_out; s_busy[1] = ifb.busy; s_done[1] = ifb.done;
        s_pass[1] = ifb.pass; s_cnt[1] = ifb.fail_cnt; s_ff[1] = ifb.first_fail; s_ffv[1] = ifb.first_fail_vld;
        for (int d = 0; d < 2; d++) begin
            h_vld[d][cyc % 16] = s_vv[d];
            h_vec[d][cyc % 16] = s_vec[d];
            idx = (cyc + 16 - lat[d]) % 16;
            if (h_vld[d][idx] != 0) in_chk[d] = !bad[d][h_vec[d][idx]];
            else in_chk[d] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_bad(input int d, input int nb, input int b0, input int b1, input bit odd);
        for (int v = 0; v < 256; v++) bad[d][v] = odd && (v % 2 == 1);
        if (nb >= 1) bad[d][b0] = 1'b1;
        if (nb >= 2) bad[d][b1] = 1'b1;
    endtask

    // expected results straight from the sweep rules
    task automatic model(input int d, input bit sol, output int e_cnt, output int e_ff,
                         output int e_ffv, output int e_pass, output int e_last);
        int first;
        first = -1;
        e_cnt = 0;
        for (int v = 0; v < nvec[d]; v++) if (bad[d][v] && first < 0) first = v;
        if (sol && first >= 0) e_last = (first + lat[d] < nvec[d]) ? first + lat[d] : nvec[d] - 1;
        else e_last = nvec[d] - 1;
        for (int v = 0; v <= e_last; v++) if (bad[d][v]) e_cnt++;
        e_ffv  = (first >= 0) ? 1 : 0;
        e_ff   = (first >= 0) ? first : 0;
        e_pass = (e_cnt == 0) ? 1 : 0;
    endtask

    task automatic run_sweep(input int d, input bit sol, input bit noise,
                             output int o_cnt, output int o_ff, output int o_ffv,
                             output int o_pass, output int o_doff, output int o_last);
        int k, issued, ord_err, busy_err;
        bit got_done;
        issued = 0; ord_err = 0; busy_err = 0; got_done = 0; o_doff = -1;
        in_sol[d] = sol;
        in_start[d] = 1'b1;
        k = cyc;
        step();
        in_start[d] = 1'b0;
        if (noise) in_sol[d] = !sol;
        check("start_clears_cnt", s_cnt[d], 0);
        check("start_clears_ffv", s_ffv[d], 0);
        check("start_clears_pass", s_pass[d], 0);
        for (int t = 0; t < 2000 && !got_done; t++) begin
            if (s_done[d] != 0) begin
                got_done = 1'b1;
                o_doff = cyc - k;
            end else begin
                if (s_vv[d] != 0) begin
                    if (s_vec[d] != issued) ord_err++;
                    issued++;
                end
                if (s_busy[d] == 0) busy_err++;
                if (noise) in_start[d] = 1'($urandom_range(0, 1));
                step();
            end
        end
        in_start[d] = 1'b0;
        check("done_seen", got_done, 1);
        check("vec_order", ord_err, 0);
        check("busy_span", busy_err, 0);
        check("busy_at_done", s_busy[d], 0);
        o_cnt = s_cnt[d]; o_ff = s_ff[d]; o_ffv = s_ffv[d]; o_pass = s_pass[d];
        o_last = issued - 1;
        step();
        check("done_one_cycle", s_done[d], 0);
        check("pass_hold", s_pass[d], o_pass);
        check("cnt_hold", s_cnt[d], o_cnt);
    endtask

    initial begin
        int o_cnt, o_ff, o_ffv, o_pass, o_doff, o_last;
        int e_cnt, e_ff, e_ffv, e_pass, e_last;
        int k, dn, vv, d, nb;
        bit sol, noise;

        lat[0] = LA; lat[1] = LB;
        nvec[0] = 1 << NA; nvec[1] = 1 << NB;
        for (int i = 0; i < 2; i++) begin
            in_start[i] = 0; in_abort[i] = 0; in_sol[i] = 0; in_chk[i] = 1;
            for (int j = 0; j < 16; j++) begin h_vld[i][j] = 0; h_vec[i][j] = 0; end
            set_bad(i, 0, 0, 0, 0);
        end

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 259};
        tbl[1] = '{0, 0, 0, 0, 2, 'h5A, 'hF0, 2, 'h5A, 1, 0, 259};
        tbl[2] = '{0, 1, 0, 0, 2, 'h5A, 'hF0, 1, 'h5A, 1, 0, 96};
        tbl[3] = '{0, 1, 1, 0, 2, 0, 1, 2, 0, 1, 0, 6};
        tbl[4] = '{0, 1, 0, 0, 2, 'hFE, 'hFF, 2, 'hFE, 1, 0, 259};
        tbl[5] = '{1, 0, 0, 1, 0, 0, 0, 4, 1, 1, 0, 9};
        tbl[6] = '{1, 1, 0, 0, 2, 3, 6, 1, 3, 1, 0, 5};
        tbl[7] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9};
        tbl[8] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 259};

        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            check("rst_vec_valid", s_vv[i], 0);
            check("rst_vec_out", s_vec[i], 0);
            check("rst_busy", s_busy[i], 0);
            check("rst_done", s_done[i], 0);
            check("rst_pass", s_pass[i], 0);
            check("rst_fail_cnt", s_cnt[i], 0);
            check("rst_first_fail", s_ff[i], 0);
            check("rst_first_fail_vld", s_ffv[i], 0);
        end
        rst = 1'b0;
        step();

        // directed table
        for (int r = 0; r < 9; r++) begin
            set_bad(tbl[r].d, tbl[r].nb, tbl[r].b0, tbl[r].b1, tbl[r].odd);
            run_sweep(tbl[r].d, tbl[r].sol, tbl[r].noise, o_cnt, o_ff, o_ffv, o_pass, o_doff, o_last);
            model(tbl[r].d, tbl[r].sol, e_cnt, e_ff, e_ffv, e_pass, e_last);
            check($sformatf("t%0d_fail_cnt", r), o_cnt, tbl[r].x_cnt);
            check($sformatf("t%0d_first_fail", r), o_ff, tbl[r].x_ff);
            check($sformatf("t%0d_first_fail_vld", r), o_ffv, tbl[r].x_ffv);
            check($sformatf("t%0d_pass", r), o_pass, tbl[r].x_pass);
            check($sformatf("t%0d_done_cycle", r), o_doff, tbl[r].x_doff);
            check($sformatf("t%0d_last_vec", r), o_last, e_last);
        end

        // abort mid-sweep: partial results kept, no done pulse
        set_bad(0, 1, 'h10, 0, 0);
        in_sol[0] = 0;
        in_start[0] = 1'b1;
        k = cyc;
        step();
        in_start[0] = 1'b0;
        for (int t = 0; t < 200 && cyc < k + 100; t++) step();
        in_abort[0] = 1'b1;
        step();
        in_abort[0] = 1'b0;
        check("abort_busy", s_busy[0], 0);
        check("abort_vec_valid", s_vv[0], 0);
        check("abort_done", s_done[0], 0);
        check("abort_pass", s_pass[0], 0);
        check("abort_fail_cnt", s_cnt[0], 1);
        check("abort_first_fail", s_ff[0], 'h10);
        check("abort_first_fail_vld", s_ffv[0], 1);
        dn = 0; vv = 0;
        for (int t = 0; t < 300; t++) begin
            step();
            dn += s_done[0];
            vv += s_vv[0];
        end
        check("abort_no_done", dn, 0);
        check("abort_no_vectors", vv, 0);
        check("abort_cnt_hold", s_cnt[0], 1);

        // start together with abort in IDLE is ignored
        in_start[0] = 1'b1; in_abort[0] = 1'b1;
        step();
        in_start[0] = 1'b0; in_abort[0] = 1'b0;
        step();
        check("start_abort_busy", s_busy[0], 0);
        check("start_abort_vec_valid", s_vv[0], 0);
        check("start_abort_cnt_kept", s_cnt[0], 1);
        set_bad(0, 0, 0, 0, 0);
        run_sweep(0, 0, 0, o_cnt, o_ff, o_ffv, o_pass, o_doff, o_last);
        check("fresh_fail_cnt", o_cnt, 0);
        check("fresh_pass", o_pass, 1);

        // synchronous reset mid-sweep, then restart with start noise
        set_bad(0, 1, 'h05, 0, 0);
        in_start[0] = 1'b1;
        k = cyc;
        step();
        in_start[0] = 1'b0;
        for (int t = 0; t < 100 && cyc < k + 50; t++) step();
        check("pre_rst_cnt", s_cnt[0], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_vec_valid", s_vv[0], 0);
        check("midrst_vec_out", s_vec[0], 0);
        check("midrst_busy", s_busy[0], 0);
        check("midrst_fail_cnt", s_cnt[0], 0);
        check("midrst_first_fail_vld", s_ffv[0], 0);
        for (int t = 0; t < 100 && cyc < k + 55; t++) step();
        set_bad(0, 1, 'h80, 0, 0);
        run_sweep(0, 0, 1, o_cnt, o_ff, o_ffv, o_pass, o_doff, o_last);
        check("restart_fail_cnt", o_cnt, 1);
        check("restart_first_fail", o_ff, 'h80);
        check("restart_done_cycle", o_doff, 259);

        // randomized sweeps against the model
        for (int r = 0; r < 6; r++) begin
            d = r % 2;
            nb = $urandom_range(0, 4);
            set_bad(d, 0, 0, 0, 0);
            for (int j = 0; j < nb; j++) bad[d][$urandom_range(0, nvec[d] - 1)] = 1'b1;
            sol = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            model(d, sol, e_cnt, e_ff, e_ffv, e_pass, e_last);
            run_sweep(d, sol, noise, o_cnt, o_ff, o_ffv, o_pass, o_doff, o_last);
            check($sformatf("r%0d_fail_cnt", r), o_cnt, e_cnt);
            check($sformatf("r%0d_first_fail", r), o_ff, e_ff);
            check($sformatf("r%0d_first_fail_vld", r), o_ffv, e_ffv);
            check($sformatf("r%0d_pass", r), o_pass, e_pass);
            check($sformatf("r%0d_last_vec", r), o_last, e_last);
            check($sformatf("r%0d_done_cycle", r), o_doff, e_last + lat[d] + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/skolem_sweep_ctrl.md
Name: skolem_sweep_ctrl

Overview:
Sequencer for exhaustive checking of a combinational Skolem-function netlist (e.g. an 8-input, 1-output bvslt/bvand Skolem function). It walks every input assignment 0..2^N_IN-1 into the function and specification checker, one vector per cycle. It then collects the pass/fail verdict returned a fixed LAT cycles later. Results are the failure count, the first failing vector and the overall pass flag. It sits between a host/test controller and the function-under-check plus its externally supplied spec predicate.

Parameters:
N_IN, 8, width of the input assignment driven to the function (i0..i(N_IN-1)).
LAT, 2, fixed cycles from vec_out presentation to the corresponding chk_ok sample; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a sweep; sampled only in IDLE.
abort  in  1  terminate a sweep in progress.
stop_on_fail  in  1  quit issuing vectors after the first failure; sampled with start and held for the sweep.
vec_out  out  N_IN  assignment driven to the function/checker.
vec_valid  out  1  vec_out is a live vector this cycle.
chk_ok  in  1  spec predicate result for the vector issued LAT cycles earlier.
busy  out  1  high in DRIVE and DRAIN.
done  out  1  one-cycle pulse at sweep completion (not on abort).
pass  out  1  sweep completed with zero failures; held until next start.
fail_cnt  out  N_IN+1  number of failing vectors; holds up to 2^N_IN, no saturation needed.
first_fail  out  N_IN  first failing vector.
first_fail_vld  out  1  first_fail is meaningful.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; vec_out=0, vec_valid=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail=0, first_fail_vld=0; delay line cleared. Reset wins over every other input, including mid-sweep.
- States: IDLE, DRIVE, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 -> DRIVE.
  - On that transition: clear fail_cnt, first_fail, first_fail_vld and pass; latch stop_on_fail; set counter=0.
  - start together with abort in IDLE: ignored, stay in IDLE.
- DRIVE:
  - vec_valid=1 and vec_out=counter; counter increments each cycle.
  - After vector 2^N_IN-1 is issued -> DRAIN. Counter wraps to 0 internally; vec_out=2^N_IN-1 is never followed by 0 in the same sweep.
- Delay line:
  - Depth LAT, carrying {valid, vector}. At its output, a valid entry samples chk_ok.
  - chk_ok=0 -> fail_cnt+1. If first_fail_vld=0, capture first_fail=vector and set first_fail_vld=1.
  - LAT=0: chk_ok is sampled in the same cycle the vector is presented.
  - chk_ok is ignored whenever the delay-line output is not valid.
- stop_on_fail latched and a failure captured while in DRIVE: vec_valid deasserts next cycle, then -> DRAIN. Vectors already in flight are still scored and counted.
- DRAIN: vec_valid=0; wait until the delay line is empty (exactly LAT cycles after the last issue), then -> DONE.
- DONE:
  - done=1 for one cycle; pass=(fail_cnt==0) becomes valid the same cycle.
  - Next state IDLE.
  - fail_cnt, first_fail, first_fail_vld and pass hold until the next accepted start.
- busy: 1 in DRIVE and DRAIN, 0 in IDLE and DONE.
- Timing: start accepted at edge k gives vec 0 in cycle k+1, vec v in cycle k+1+v, and done in cycle k+2^N_IN+LAT+1 (full sweep).
- start in DRIVE, DRAIN or DONE: ignored.
- abort in DRIVE or DRAIN:
  - Next state IDLE; vec_valid=0; delay line flushed.
  - done is not pulsed and pass=0; fail_cnt and first_fail keep their partial values.
- abort in IDLE or DONE: no effect (DONE still pulses done).
- Arithmetic: counter is N_IN+1 bits so terminal detection is exact; fail_cnt is N_IN+1 bits and unsigned.

Test Plan:
1. N_IN=8, LAT=2, chk_ok tied 1, start at cycle 0 -> vec_out runs 0..255 in cycles 1..256; done in cycle 259; pass=1, fail_cnt=0, first_fail_vld=0.
2. chk_ok=0 only when the delay-line vector is 8'h5A or 8'hF0 -> done in cycle 259; pass=0, fail_cnt=2, first_fail=8'h5A, first_fail_vld=1.
3. Same stimulus as scenario 2 with stop_on_fail=1 at start:
   - vec 8'h5A is issued in cycle 91 and scored in cycle 93.
   - vec_valid drops from cycle 94; the in-flight vecs 8'h5B and 8'h5C are scored.
   - done pulses 2 cycles later; fail_cnt=1, first_fail=8'h5A.
4. abort=1 in cycle 100 with chk_ok=0 for vec 8'h10 -> IDLE in cycle 101, no done pulse, pass=0, fail_cnt=1, first_fail=8'h10; then a fresh start clears fail_cnt to 0.
5. rst=1 in cycle 50 mid-sweep -> all outputs 0 at cycle 51; start at 55 restarts from vec 0; start pulses in DRIVE are ignored and do not reset the counter.
6. LAT=0, N_IN=3, chk_ok = ~vec_out[0] -> done in cycle 9; fail_cnt=4, first_fail=3'd1, pass=0.
